seq_bit_serializer: RTL and testbench



---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_bit_serializer_if.sv | 12 +
 rtl/seq_bit_serializer.sv | 149 ++++++++++++++
 tb/tb_seq_bit_serializer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector family and its serial feeder:
// the feeder FSM encoding, the default idle level of the serial line and the
// detector state encodings used by both detector and feeder benches.
package seq_det_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam logic SER_IDLE_BIT_DEFAULT = 1'b0;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } det_state_t;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Parallel-word valid/ready handshake feeding seq_bit_serializer.
// master = word producer, slave = serializer.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the serial sequence detectors.
// Words arrive over a valid/ready handshake and are shifted out one bit per
// clock on ser_out. A one-word holding buffer lets consecutive words stream
// without an idle bit between them. All outputs are registered; reset is
// asynchronous and active-low.
// Optional build macro SER_PARITY_EN: appends an even-parity bit after the
// WIDTH data bits of every word.
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = SER_IDLE_BIT_DEFAULT,
    parameter int   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_bit_serializer_if.slave  bus,
    output logic                 ser_out,
    output logic                 ser_valid,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_cnt
);

`ifdef SER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int              BC_W     = $clog2(NBITS);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(NBITS - 1);
`ifdef SER_PARITY_EN
    // Index of the last data bit; the bit after it is the parity bit.
    localparam logic [BC_W-1:0] PAR_IDX  = BC_W'(WIDTH - 1);
`endif

    ser_state_t        state;
    logic [WIDTH-1:0]  shreg;      // bits still to be sent after the current one
    logic [WIDTH-1:0]  hold_buf;
    logic              hold_vld;
    logic [BC_W-1:0]   bit_cnt;    // index of the bit currently on ser_out
    logic              ser_out_r;
    logic              ser_valid_r;
    logic              busy_r;
    logic              in_ready_r;
    logic [CNT_W-1:0]  word_cnt_r;
`ifdef SER_PARITY_EN
    logic              par_r;
`endif

    logic              xfer;
    logic              last_bit;
    logic [WIDTH-1:0]  load_src;
    logic              next_bit;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign xfer     = bus.in_valid & in_ready_r;
    assign last_bit = (bit_cnt == LAST_IDX);
    // In SER_IDLE hold_vld is always 0, so this also selects in_data there.
    assign load_src = hold_vld ? hold_buf : bus.in_data;

    // Select the bit that follows the current one within the word.
    always_comb begin
        next_bit = first_bit(shreg);
`ifdef SER_PARITY_EN
        if (bit_cnt == PAR_IDX) next_bit = par_r;
`endif
    end

    // Serializer FSM: loads, shifts, reloads from the holding buffer, counts words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SER_IDLE;
            shreg       <= '0;
            hold_buf    <= '0;
            hold_vld    <= 1'b0;
            bit_cnt     <= '0;
            ser_out_r   <= IDLE_BIT;
            ser_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            word_cnt_r  <= '0;
`ifdef SER_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            case (state)
                SER_IDLE: begin
                    if (xfer) begin
                        shreg       <= shift_word(load_src);
                        ser_out_r   <= first_bit(load_src);
                        bit_cnt     <= '0;
`ifdef SER_PARITY_EN
                        par_r       <= ^load_src;
`endif
                        state       <= SER_SHIFT;
                        ser_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                SER_SHIFT: begin
                    if (last_bit) begin
                        word_cnt_r <= word_cnt_r + CNT_W'(1);
                        // A held word and a new transfer never coincide: in_ready is low while holding.
                        if (hold_vld || xfer) begin
                            shreg      <= shift_word(load_src);
                            ser_out_r  <= first_bit(load_src);
                            bit_cnt    <= '0;
`ifdef SER_PARITY_EN
                            par_r      <= ^load_src;
`endif
                            hold_vld   <= 1'b0;
                            in_ready_r <= 1'b1;
                        end else begin
                            state       <= SER_IDLE;
                            ser_out_r   <= IDLE_BIT;
                            ser_valid_r <= 1'b0;
                            busy_r      <= 1'b0;
                        end
                    end else begin
                        ser_out_r <= next_bit;
                        shreg     <= shift_word(shreg);
                        bit_cnt   <= bit_cnt + BC_W'(1);
                        if (xfer) begin
                            hold_buf   <= bus.in_data;
                            hold_vld   <= 1'b1;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_r;
    assign ser_out      = ser_out_r;
    assign ser_valid    = ser_valid_r;
    assign busy         = busy_r;
    assign word_cnt     = word_cnt_r;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed self-checking bench for seq_bit_serializer.
// u0: WIDTH=8, MSB first, idle 0, 16-bit counter.
// u1: WIDTH=8, LSB first, idle 0, 4-bit counter (wrap check).
module tb_seq_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(W)) bus0 ();
    seq_bit_serializer_if #(.WIDTH(W)) bus1 ();

    logic        so0, sv0, busy0;
    logic [15:0] cnt0;
    logic        so1, sv1, busy1;
    logic [3:0]  cnt1;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .ser_out(so0), .ser_valid(sv0), .busy(busy0), .word_cnt(cnt0)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .ser_out(so1), .ser_valid(sv1), .busy(busy1), .word_cnt(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        #2 rst = 1'b0;
        #2;
        n_checks++; if (so0 !== 1'b0)    begin n_fail++; $display("FAIL reset_ser_out0 got %b exp 0", so0); end
        n_checks++; if (sv0 !== 1'b0)    begin n_fail++; $display("FAIL reset_ser_valid0 got %b exp 0", sv0); end
        n_checks++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy0 got %b exp 0", busy0); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready0 got %b exp 1", bus0.in_ready); end
        n_checks++; if (cnt0 !== 16'd0)  begin n_fail++; $display("FAIL reset_word_cnt0 got %0d exp 0", cnt0); end
        n_checks++; if (sv1 !== 1'b0)    begin n_fail++; $display("FAIL reset_ser_valid1 got %b exp 0", sv1); end
        n_checks++; if (cnt1 !== 4'd0)   begin n_fail++; $display("FAIL reset_word_cnt1 got %0d exp 0", cnt1); end
        @(posedge clk); #1 rst = 1'b1;
        step();
    endtask

    // 8'hA0 MSB first: 1,0,1,0,0,0,0,0 (+ parity 0); a 101 detector fires once, on the third bit.
    task automatic test_single_word();
        logic [NB-1:0] exp;
        logic [1:0]    hist;
        int            hits;
        int            hit_k;
`ifdef SER_PARITY_EN
        exp = 9'b1010_0000_0;
`else
        exp = 8'b1010_0000;
`endif
        hist = 2'b00; hits = 0; hit_k = -1;
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", bus0.in_ready); end
        bus0.in_data = 8'hA0; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if ({sv0, so0} !== {1'b1, exp[NB-1-k]}) begin
                n_fail++; $display("FAIL single_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, exp[NB-1-k]);
            end
            if (sv0 === 1'b1) begin
                if (hist == 2'b10 && so0 === 1'b1) begin hits++; hit_k = k; end
                hist = {hist[0], so0};
            end
            step();
        end
        n_checks++; if ({sv0, so0} !== 2'b00) begin n_fail++; $display("FAIL single_idle got valid/bit %b%b exp 00", sv0, so0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b exp 0", busy0); end
        n_checks++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL single_word_cnt got %0d exp 1", cnt0); end
        n_checks++; if (hits != 1 || hit_k != 2) begin n_fail++; $display("FAIL single_det101 got hits=%0d at %0d exp 1 at 2", hits, hit_k); end
    endtask

    // 8'hFF then 8'h00, second one held while the first shifts: contiguous stream.
    task automatic test_back_to_back();
        logic [2*NB-1:0] exp;
        logic            exp_rdy;
`ifdef SER_PARITY_EN
        exp = 18'b1111_1111_0_0000_0000_0;
`else
        exp = 16'b1111_1111_0000_0000;
`endif
        bus0.in_data = 8'hFF; bus0.in_valid = 1'b1;
        step();
        bus0.in_data = 8'h00;
        for (int k = 0; k < 2*NB; k++) begin
            exp_rdy = (k >= 1 && k < NB) ? 1'b0 : 1'b1;
            n_checks++;
            if ({sv0, so0} !== {1'b1, exp[2*NB-1-k]}) begin
                n_fail++; $display("FAIL b2b_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, exp[2*NB-1-k]);
            end
            n_checks++;
            if (bus0.in_ready !== exp_rdy) begin
                n_fail++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, bus0.in_ready, exp_rdy);
            end
            n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got %b exp 1", k, busy0); end
            step();
            if (k == 0) bus0.in_valid = 1'b0;
        end
        n_checks++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL b2b_end_valid got %b exp 0", sv0); end
        // cumulative: one word from the previous test plus these two
        n_checks++; if (cnt0 !== 16'd3) begin n_fail++; $display("FAIL b2b_word_cnt got %0d exp 3", cnt0); end
    endtask

    // 8'h81, then 8'h3C offered exactly on the last-bit edge with the hold buffer empty.
    task automatic test_last_bit_edge();
        logic [2*NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = 18'b1000_0001_0_0011_1100_0;
`else
        exp = 16'b1000_0001_0011_1100;
`endif
        bus0.in_data = 8'h81; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        for (int k = 0; k < 2*NB; k++) begin
            if (k == NB-1) begin
                n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL edge_ready got %b exp 1", bus0.in_ready); end
                bus0.in_data = 8'h3C; bus0.in_valid = 1'b1;
            end
            n_checks++;
            if ({sv0, so0} !== {1'b1, exp[2*NB-1-k]}) begin
                n_fail++; $display("FAIL edge_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, exp[2*NB-1-k]);
            end
            step();
            if (k == NB-1) bus0.in_valid = 1'b0;
        end
        n_checks++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL edge_end_valid got %b exp 0", sv0); end
        n_checks++; if (cnt0 !== 16'd5) begin n_fail++; $display("FAIL edge_word_cnt got %0d exp 5", cnt0); end
    endtask

    // Reset after 3 bits of 8'hA5 with 8'h3C held, then 8'h01 shifts cleanly.
    task automatic test_reset_mid();
        logic [NB-1:0] exp;
        logic [2:0]    head;
`ifdef SER_PARITY_EN
        exp = 9'b0000_0001_1;
`else
        exp = 8'b0000_0001;
`endif
        head = 3'b101;
        bus0.in_data = 8'hA5; bus0.in_valid = 1'b1;
        step();
        bus0.in_data = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({sv0, so0} !== {1'b1, head[2-k]}) begin
                n_fail++; $display("FAIL rmid_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, head[2-k]);
            end
            if (k < 2) step();
            if (k == 0) bus0.in_valid = 1'b0;
        end
        n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_held_ready got %b exp 0", bus0.in_ready); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({sv0, so0} !== 2'b00) begin n_fail++; $display("FAIL rmid_out got valid/bit %b%b exp 00", sv0, so0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy0); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b exp 1", bus0.in_ready); end
        n_checks++; if (cnt0 !== 16'd0) begin n_fail++; $display("FAIL rmid_word_cnt got %0d exp 0", cnt0); end
        @(negedge clk) rst = 1'b1;
        step();
        bus0.in_data = 8'h01; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if ({sv0, so0} !== {1'b1, exp[NB-1-k]}) begin
                n_fail++; $display("FAIL rmid_after_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, exp[NB-1-k]);
            end
            step();
        end
        n_checks++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL rmid_after_valid got %b exp 0", sv0); end
        n_checks++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL rmid_after_cnt got %0d exp 1", cnt0); end
    endtask

    // LSB first, 8'h05: 1,0,1,0,0,0,0,0 (+ parity 0).
    task automatic test_lsb_first();
        logic [NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = 9'b1010_0000_0;
`else
        exp = 8'b1010_0000;
`endif
        bus1.in_data = 8'h05; bus1.in_valid = 1'b1;
        step();
        bus1.in_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if ({sv1, so1} !== {1'b1, exp[NB-1-k]}) begin
                n_fail++; $display("FAIL lsb_bit[%0d] got valid/bit %b%b exp 1%b", k, sv1, so1, exp[NB-1-k]);
            end
            step();
        end
        n_checks++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL lsb_end_valid got %b exp 0", sv1); end
        n_checks++; if (cnt1 !== 4'd1) begin n_fail++; $display("FAIL lsb_word_cnt got %0d exp 1", cnt1); end
    endtask

    // 4-bit counter: 16th word wraps to 0, 17th reads 1 (one word already sent above).
    task automatic test_cnt_wrap();
        for (int w = 0; w < 16; w++) begin
            bus1.in_data = W'(w * 3 + 1); bus1.in_valid = 1'b1;
            step();
            bus1.in_valid = 1'b0;
            repeat (NB) step();
            n_checks++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL wrap_idle[%0d] got %b exp 0", w, sv1); end
            if (w == 13) begin
                n_checks++; if (cnt1 !== 4'd15) begin n_fail++; $display("FAIL wrap_cnt15 got %0d exp 15", cnt1); end
            end
            if (w == 14) begin
                n_checks++; if (cnt1 !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt16 got %0d exp 0", cnt1); end
            end
            if (w == 15) begin
                n_checks++; if (cnt1 !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt17 got %0d exp 1", cnt1); end
            end
        end
    endtask

    // 8'h07: with parity 9 valid bits ending in 1, otherwise 8 bits 00000111.
    task automatic test_parity();
        logic [NB-1:0] exp;
`ifdef SER_PARITY_EN
        exp = 9'b0000_0111_1;
`else
        exp = 8'b0000_0111;
`endif
        bus0.in_data = 8'h07; bus0.in_valid = 1'b1;
        step();
        bus0.in_valid = 1'b0;
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if ({sv0, so0} !== {1'b1, exp[NB-1-k]}) begin
                n_fail++; $display("FAIL par_bit[%0d] got valid/bit %b%b exp 1%b", k, sv0, so0, exp[NB-1-k]);
            end
            step();
        end
        n_checks++; if (sv0 !== 1'b0) begin n_fail++; $display("FAIL par_end_valid got %b exp 0", sv0); end
        n_checks++; if (cnt0 !== 16'd2) begin n_fail++; $display("FAIL par_word_cnt got %0d exp 2", cnt0); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_last_bit_edge();
        test_reset_mid();
        test_lsb_first();
        test_cnt_wrap();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
